// File: rtl/inst_decode_stage.sv
// Registered instruction-decode stage between fetch and register read.
// Splits the instruction word into its fields and adds sign/zero-extended
// immediates and a jump target. Valid/ready handshake on both sides. SKID=1
// uses a two-entry buffer so in_ready comes straight from a flop; SKID=0 is a
// single entry with a combinational in_ready. A saturating counter reports
// downstream stall cycles.
module inst_decode_stage #(
    parameter int XLEN  = 32,
    parameter int PC_W  = 32,
    parameter int SKID  = 1,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_inst,
    input  logic [PC_W-1:0]  in_pc,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [PC_W-1:0]  out_pc,
    output logic [5:0]       out_opecode,
    output logic [4:0]       out_rd,
    output logic [4:0]       out_rs,
    output logic [4:0]       out_rt,
    output logic [4:0]       out_shamt,
    output logic [5:0]       out_funct,
    output logic [XLEN-1:0]  out_immd_sext,
    output logic [XLEN-1:0]  out_immd_zext,
    output logic [PC_W-1:0]  out_jtarget,
    output logic [CNT_W-1:0] stall_cnt
);

    typedef struct packed {
        logic [PC_W-1:0] pc;
        logic [5:0]      opecode;
        logic [4:0]      rd;
        logic [4:0]      rs;
        logic [4:0]      rt;
        logic [4:0]      shamt;
        logic [5:0]      funct;
        logic [XLEN-1:0] sext;
        logic [XLEN-1:0] zext;
        logic [PC_W-1:0] jtarget;
    } dec_t;

    dec_t            dec_in;
    dec_t            main_q;
    logic [PC_W-1:0] jtarget;
    logic            in_fire;
    logic            out_fire;

    assign in_fire  = in_valid && in_ready;
    assign out_fire = out_valid && out_ready;

    // Only the bits above 28 of pc+4 reach the jump target, so build them as
    // pc[hi] plus a carry out of the 26-bit word index; wraps modulo 2^PC_W.
    generate
        if (PC_W > 28) begin : g_jt_hi
            logic carry;
            assign carry   = &in_pc[27:2];
            assign jtarget = {in_pc[PC_W-1:28] + (PC_W-28)'(carry), in_inst[25:0], 2'b00};
        end else begin : g_jt_lo
            assign jtarget = {in_inst[25:0], 2'b00};
        end
    endgenerate

    // Field split and immediate extension of the incoming word
    always_comb begin
        dec_in         = '0;
        dec_in.pc      = in_pc;
        dec_in.opecode = in_inst[31:26];
        dec_in.rd      = in_inst[25:21];
        dec_in.rs      = in_inst[20:16];
        dec_in.rt      = in_inst[15:11];
        dec_in.shamt   = in_inst[10:6];
        dec_in.funct   = in_inst[5:0];
        dec_in.sext    = XLEN'($signed(in_inst[15:0]));
        dec_in.zext    = XLEN'(in_inst[15:0]);
        dec_in.jtarget = jtarget;
    end

    generate
        if (SKID != 0) begin : g_skid
            typedef enum logic [1:0] {EMPTY, FULL1, FULL2} st_t;
            st_t  state, state_nxt;
            dec_t skid_q;

            // State register
            always_ff @(posedge clk or negedge rstn) begin
                if (!rstn) state <= EMPTY;
                else       state <= state_nxt;
            end

            // Next state; flush beats any transfer in the same cycle
            always_comb begin
                state_nxt = state;
                if (flush) begin
                    state_nxt = EMPTY;
                end else begin
                    case (state)
                        EMPTY: if (in_fire) state_nxt = FULL1;
                        FULL1: begin
                            if (in_fire && !out_fire)      state_nxt = FULL2;
                            else if (!in_fire && out_fire) state_nxt = EMPTY;
                        end
                        FULL2: if (out_fire) state_nxt = FULL1;
                        default: state_nxt = EMPTY;
                    endcase
                end
            end

            // Handshake outputs decoded from the registered state only
            always_comb begin
                in_ready  = (state != FULL2);
                out_valid = (state != EMPTY);
            end

            // Main entry feeds the outputs; skid catches the word that
            // arrives while main is stalled
            always_ff @(posedge clk or negedge rstn) begin
                if (!rstn) begin
                    main_q <= '0;
                    skid_q <= '0;
                end else if (!flush) begin
                    case (state)
                        EMPTY: if (in_fire) main_q <= dec_in;
                        FULL1: begin
                            if (in_fire && out_fire) main_q <= dec_in;
                            else if (in_fire)        skid_q <= dec_in;
                        end
                        FULL2: if (out_fire) main_q <= skid_q;
                        default: ;
                    endcase
                end
            end
        end else begin : g_single
            logic vld_q;

            // Single-entry occupancy; a fire on both sides keeps it full
            always_ff @(posedge clk or negedge rstn) begin
                if (!rstn)         vld_q <= 1'b0;
                else if (flush)    vld_q <= 1'b0;
                else if (in_fire)  vld_q <= 1'b1;
                else if (out_fire) vld_q <= 1'b0;
            end

            // Accept whenever the entry is empty or draining this cycle
            always_comb begin
                out_valid = vld_q;
                in_ready  = !vld_q || out_ready;
            end

            // Entry payload
            always_ff @(posedge clk or negedge rstn) begin
                if (!rstn)                  main_q <= '0;
                else if (!flush && in_fire) main_q <= dec_in;
            end
        end
    endgenerate

    // Saturating count of cycles the consumer holds us off
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)
            stall_cnt <= '0;
        else if (out_valid && !out_ready && !(&stall_cnt))
            stall_cnt <= stall_cnt + 1'b1;
    end

    assign out_pc        = main_q.pc;
    assign out_opecode   = main_q.opecode;
    assign out_rd        = main_q.rd;
    assign out_rs        = main_q.rs;
    assign out_rt        = main_q.rt;
    assign out_shamt     = main_q.shamt;
    assign out_funct     = main_q.funct;
    assign out_immd_sext = main_q.sext;
    assign out_immd_zext = main_q.zext;
    assign out_jtarget   = main_q.jtarget;

endmodule

// File: tb/tb_inst_decode_stage.sv
// Bench for inst_decode_stage: one SKID=1 instance (default widths) and one
// SKID=0 instance with a 4-bit stall counter. Accepted words are queued per
// instance and checked in order as they leave.
module tb_inst_decode_stage;

    typedef struct {
        logic [31:0] inst;
        logic [31:0] pc;
    } item_t;

    logic clk = 1'b0;
    logic rstn;
    always #5 clk = ~clk;

    // SKID=1 instance
    logic        fl1, v1, r1, rdy1, ov1;
    logic [31:0] inst1, pc1, o_pc1, sx1, zx1, jt1;
    logic [5:0]  op1, fn1;
    logic [4:0]  rd1, rs1, rt1, sh1;
    logic [15:0] st1;

    // SKID=0 instance
    logic        fl0, v0, r0, rdy0, ov0;
    logic [31:0] inst0, pc0, o_pc0, sx0, zx0, jt0;
    logic [5:0]  op0, fn0;
    logic [4:0]  rd0, rs0, rt0, sh0;
    logic [3:0]  st0;

    inst_decode_stage #(.XLEN(32), .PC_W(32), .SKID(1), .CNT_W(16)) dut1 (
        .clk(clk), .rstn(rstn), .flush(fl1), .in_valid(v1), .in_ready(rdy1),
        .in_inst(inst1), .in_pc(pc1), .out_valid(ov1), .out_ready(r1),
        .out_pc(o_pc1), .out_opecode(op1), .out_rd(rd1), .out_rs(rs1), .out_rt(rt1),
        .out_shamt(sh1), .out_funct(fn1), .out_immd_sext(sx1), .out_immd_zext(zx1),
        .out_jtarget(jt1), .stall_cnt(st1)
    );

    inst_decode_stage #(.XLEN(32), .PC_W(32), .SKID(0), .CNT_W(4)) dut0 (
        .clk(clk), .rstn(rstn), .flush(fl0), .in_valid(v0), .in_ready(rdy0),
        .in_inst(inst0), .in_pc(pc0), .out_valid(ov0), .out_ready(r0),
        .out_pc(o_pc0), .out_opecode(op0), .out_rd(rd0), .out_rs(rs0), .out_rt(rt0),
        .out_shamt(sh0), .out_funct(fn0), .out_immd_sext(sx0), .out_immd_zext(zx0),
        .out_jtarget(jt0), .stall_cnt(st0)
    );

    int    n_tests = 0;
    int    n_fail  = 0;
    item_t sb1[$];
    item_t sb0[$];
    item_t e1, e0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference decode of a queued word against what left the stage
    task automatic chk_dec(input string tag, input item_t e, input logic [31:0] pc,
                           input logic [31:0] fld, input logic [31:0] sx,
                           input logic [31:0] zx, input logic [31:0] jt);
        logic [31:0] exp_sx, exp_jt;
        exp_sx = {{16{e.inst[15]}}, e.inst[15:0]};
        exp_jt = ((e.pc + 32'd4) & 32'hF000_0000) | ((e.inst & 32'h03FF_FFFF) << 2);
        chk({tag, "_pc"}, pc, e.pc);
        chk({tag, "_fields"}, fld, e.inst);
        chk({tag, "_sext"}, sx, exp_sx);
        chk({tag, "_zext"}, zx, e.inst & 32'h0000_FFFF);
        chk({tag, "_jt"}, jt, exp_jt);
    endtask

    // Scoreboard for SKID=1: pop on out fire, push on accepted in
    always @(negedge clk) begin
        if (rstn) begin
            if (ov1 && r1) begin
                if (sb1.size() == 0) chk("sb1_unexpected_out", 32'(sb1.size()), 32'd1);
                else begin
                    e1 = sb1.pop_front();
                    chk_dec("dec1", e1, o_pc1, {op1, rd1, rs1, rt1, sh1, fn1}, sx1, zx1, jt1);
                end
            end
            if (v1 && rdy1 && !fl1) sb1.push_back('{inst1, pc1});
        end
    end

    // Scoreboard for SKID=0, plus the combinational in_ready relation
    always @(negedge clk) begin
        if (rstn) begin
            chk("rdy0_rel", {31'd0, rdy0}, {31'd0, !ov0 || r0});
            if (ov0 && r0) begin
                if (sb0.size() == 0) chk("sb0_unexpected_out", 32'(sb0.size()), 32'd1);
                else begin
                    e0 = sb0.pop_front();
                    chk_dec("dec0", e0, o_pc0, {op0, rd0, rs0, rt0, sh0, fn0}, sx0, zx0, jt0);
                end
            end
            if (v0 && rdy0 && !fl0) sb0.push_back('{inst0, pc0});
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rstn = 1'b1;
        fl1 = 0; v1 = 0; r1 = 0; inst1 = 0; pc1 = 0;
        fl0 = 0; v0 = 0; r0 = 0; inst0 = 0; pc0 = 0;
        #1 rstn = 1'b0;
        #2;
        // Reset state
        chk("rst_ov1", ov1, 0);
        chk("rst_rdy1", rdy1, 1);
        chk("rst_pc1", o_pc1, 0);
        chk("rst_fld1", {op1, rd1, rs1, rt1, sh1, fn1}, 0);
        chk("rst_imm1", sx1 | zx1 | jt1, 0);
        chk("rst_st1", st1, 0);
        chk("rst_ov0", ov0, 0);
        chk("rst_rdy0", rdy0, 1);
        chk("rst_st0", st0, 0);
        chk("rst_out0", o_pc0 | sx0 | zx0 | jt0, 0);
        @(posedge clk); #1 rstn = 1'b1;
        @(posedge clk); #1;

        // Decode example, then a pc at the top of the address space
        r1 = 1; v1 = 1; inst1 = 32'h2128FFFC; pc1 = 32'h0040_0000;
        @(posedge clk); #1;
        chk("t2_valid", ov1, 1);
        chk("t2_op", op1, 32'h08);
        chk("t2_rd", rd1, 32'h09);
        chk("t2_rs", rs1, 32'h08);
        chk("t2_rt", rt1, 32'h1F);
        chk("t2_shamt", sh1, 32'h1F);
        chk("t2_funct", fn1, 32'h3C);
        chk("t2_sext", sx1, 32'hFFFF_FFFC);
        chk("t2_zext", zx1, 32'h0000_FFFC);
        chk("t2_jt", jt1, 32'h04A3_FFF0);
        inst1 = 32'hFC00_0003; pc1 = 32'hFFFF_FFFC;
        @(posedge clk); #1;
        chk("wrap_valid", ov1, 1);
        chk("wrap_jt", jt1, 32'h0000_000C);
        chk("wrap_sext", sx1, 32'h0000_0003);
        v1 = 0;
        @(posedge clk); #1;
        chk("t2_drained", ov1, 0);
        chk("t2_stall", st1, 0);

        // Backpressure: A and B accepted, C held until the consumer opens
        r1 = 0; v1 = 1; inst1 = 32'hAAAA_0001; pc1 = 32'h0000_1000;
        @(posedge clk); #1;
        inst1 = 32'hBBBB_8002; pc1 = 32'h0000_1004;
        @(posedge clk); #1;
        chk("bp_rdy_after_b", rdy1, 0);
        inst1 = 32'hCCCC_0003; pc1 = 32'h0000_1008;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            chk("bp_rdy_hold", rdy1, 0);
            chk("bp_ov_hold", ov1, 1);
            chk("bp_pc_stable", o_pc1, 32'h0000_1000);
        end
        chk("bp_stall", st1, 4);
        r1 = 1;
        @(posedge clk); #1;
        chk("bp_gap_b", ov1, 1);
        chk("bp_rdy_reopen", rdy1, 1);
        @(posedge clk); #1;
        chk("bp_gap_c", ov1, 1);
        v1 = 0;
        @(posedge clk); #1;
        chk("bp_done", ov1, 0);
        chk("bp_stall_final", st1, 4);
        chk("bp_sb_empty", 32'(sb1.size()), 0);

        // Flush while FULL2 with a word offered
        r1 = 0; v1 = 1; inst1 = 32'hD000_0004; pc1 = 32'h0000_2000;
        @(posedge clk); #1;
        inst1 = 32'hE000_0005; pc1 = 32'h0000_2004;
        @(posedge clk); #1;
        chk("fl_full2", rdy1, 0);
        inst1 = 32'hF000_0006; pc1 = 32'h0000_2008;
        fl1 = 1; r1 = 1;
        @(posedge clk); #1;
        fl1 = 0; v1 = 0;
        chk("fl_ov", ov1, 0);
        chk("fl_rdy", rdy1, 1);
        chk("fl_stall", st1, 5);
        sb1.delete();
        // Flush while FULL1 with an in fire in the same cycle
        r1 = 0; v1 = 1; inst1 = 32'h1111_0007; pc1 = 32'h0000_3000;
        @(posedge clk); #1;
        inst1 = 32'h2222_0008; pc1 = 32'h0000_3004;
        fl1 = 1;
        @(posedge clk); #1;
        fl1 = 0; v1 = 0;
        chk("fl1_ov", ov1, 0);
        chk("fl1_rdy", rdy1, 1);
        chk("fl1_stall", st1, 6);
        sb1.delete();
        r1 = 1;
        repeat (3) begin
            @(posedge clk); #1;
            chk("fl_quiet", ov1, 0);
        end

        // Saturation on the 4-bit counter
        r0 = 0; v0 = 1; inst0 = 32'h3333_9999; pc0 = 32'h0000_4000;
        @(posedge clk); #1;
        v0 = 0;
        repeat (14) @(posedge clk);
        #1 chk("sat_14", st0, 14);
        @(posedge clk); #1;
        chk("sat_15", st0, 15);
        repeat (6) @(posedge clk);
        #1 chk("sat_hold", st0, 15);
        chk("sat_ov", ov0, 1);
        r0 = 1;
        @(posedge clk); #1;
        chk("sat_drain", ov0, 0);

        // Random traffic on the single-entry stage
        for (int i = 0; i < 1000; i++) begin
            v0 = 1'($urandom_range(0, 1));
            r0 = 1'($urandom_range(0, 1));
            inst0 = $urandom;
            pc0 = $urandom;
            @(posedge clk); #1;
        end
        v0 = 0; r0 = 1;
        repeat (3) @(posedge clk);
        #1 chk("rnd_sb_empty", 32'(sb0.size()), 0);

        // Full-rate stream: one word out per cycle
        v0 = 1; r0 = 1;
        for (int i = 0; i < 20; i++) begin
            inst0 = $urandom; pc0 = $urandom;
            @(posedge clk); #1;
            chk("rate0", ov0, 1);
        end
        v0 = 0;
        @(posedge clk); #1;
        chk("rate_end", ov0, 0);
        chk("rate_sb_empty", 32'(sb0.size()), 0);

        // Reset in the middle of a held word clears immediately
        r1 = 0; v1 = 1; inst1 = 32'h5555_AAAA; pc1 = 32'h0000_5000;
        @(posedge clk); #1;
        v1 = 0;
        @(posedge clk); #1;
        chk("mid_pre_ov", ov1, 1);
        #1 rstn = 1'b0;
        #1;
        chk("mid_ov", ov1, 0);
        chk("mid_pc", o_pc1, 0);
        chk("mid_stall", st1, 0);
        chk("mid_rdy", rdy1, 1);
        sb1.delete();
        sb0.delete();
        @(posedge clk); #1 rstn = 1'b1;
        r1 = 1;
        @(posedge clk); #1;
        chk("mid_after", ov1, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
